instruction_encoder: RTL and testbench

Packs decoded instruction fields (opcode, register indices, immediate) into the processor's 32-bit instruction word. It is the encoding counterpart of the decode stage and uses the same bit layout. Encoded words are buffered in a small FIFO and each word is tagged with a sequential program-memory address, so a loader or test harness can stream instructions into instruction memory.

---
 rtl/instruction_encoder.sv | 168 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs decoded instruction fields into 32-bit words
// and queues them with sequential program-memory address tags.
module instruction_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            opcode,
  input  logic [4:0]            R,
  input  logic [4:0]            Rd,
  input  logic [4:0]            Rs,
  input  logic [4:0]            Rb,
  input  logic [4:0]            M,
  input  logic [31:0]           immediate,
  input  logic                  base_load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_word,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  illegal_opcode,
  output logic                  imm_truncated,
  input  logic                  clear_flags
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]           r_mem_word [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [31:0]           r_last_word;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_illegal;
  logic                  r_trunc;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_trunc_hit;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH-1:0] w_tag;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // reset gates in_ready so nothing is offered as acceptable while held in reset
  assign in_ready = reset & ~w_full;
  assign w_accept = in_valid & in_ready;
  assign w_legal  = (opcode <= 5'd18);
  assign w_push   = w_accept & w_legal;
  assign w_pop    = ~w_empty & out_ready;
  assign w_tag    = base_load ? base_addr : r_next_addr;

  always_comb begin
    w_word = '0;
    w_word[31:27] = opcode;
    case (opcode)
      5'd0: begin
        w_word[26:22] = Rd;
        w_word[21:6]  = immediate[31:16];
        w_word[4:0]   = Rb;
      end
      5'd1: begin
        w_word[26:22] = Rs;
        w_word[21:6]  = immediate[31:16];
        w_word[4:0]   = Rb;
      end
      5'd2: begin
        w_word[26:22] = Rd;
        w_word[4:0]   = Rs;
      end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12: begin
        w_word[21:17] = Rd;
        w_word[16:12] = Rs;
      end
      5'd13, 5'd16: begin
        w_word[14:10] = R;
      end
      5'd14: begin
        w_word[13:7]  = immediate[22:16];
      end
      5'd15: begin
        w_word[14:10] = R;
        w_word[9:5]   = immediate[4:0];
        w_word[4:0]   = M;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_trunc_hit = 1'b0;
    case (opcode)
      5'd0, 5'd1: w_trunc_hit = (immediate[15:0] != 16'd0);
      5'd14:      w_trunc_hit = (immediate[31:23] != 9'd0) || (immediate[15:0] != 16'd0);
      5'd15:      w_trunc_hit = (immediate[31:5] != 27'd0);
      default:    w_trunc_hit = 1'b0;
    endcase
  end

  // storage needs no reset: only entries between the pointers are ever shown
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_word[r_wr_ptr] <= w_word;
      r_mem_addr[r_wr_ptr] <= w_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_next_addr <= '0;
      r_last_word <= '0;
      r_last_addr <= '0;
      r_illegal   <= 1'b0;
      r_trunc     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_push) begin
        r_next_addr <= w_tag + ADDR_WIDTH'(1);
      end else if (base_load) begin
        r_next_addr <= base_addr;
      end

      if (!w_empty) begin
        r_last_word <= r_mem_word[r_rd_ptr];
        r_last_addr <= r_mem_addr[r_rd_ptr];
      end

      r_illegal <= w_accept & ~w_legal;

      if (w_accept && w_legal && w_trunc_hit) begin
        r_trunc <= 1'b1;
      end else if (clear_flags) begin
        r_trunc <= 1'b0;
      end
    end
  end

  assign out_valid      = ~w_empty;
  assign out_word       = w_empty ? r_last_word : r_mem_word[r_rd_ptr];
  assign out_addr       = w_empty ? r_last_addr : r_mem_addr[r_rd_ptr];
  assign illegal_opcode = r_illegal;
  assign imm_truncated  = r_trunc;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - randomized self-checking bench for instruction_encoder
// against a queue-based reference model.
module tb_instruction_encoder;
  localparam int AW = 8;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    opcode, R, Rd, Rs, Rb, M;
  logic [31:0]   immediate;
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          illegal_opcode;
  logic          imm_truncated;
  logic          clear_flags;

  instruction_encoder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .R(R), .Rd(Rd), .Rs(Rs), .Rb(Rb), .M(M), .immediate(immediate),
    .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
    .illegal_opcode(illegal_opcode), .imm_truncated(imm_truncated),
    .clear_flags(clear_flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]   w;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_next;
  logic [31:0]   m_last_w;
  logic [AW-1:0] m_last_a;
  logic          m_trunc;
  logic          m_ill;
  logic          m_acc;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [31:0] op, r, rd, rs, rb, m, imm);
    logic [31:0] w;
    w = op << 27;
    if (op <= 1)       w = w + (((op == 0) ? rd : rs) << 22) + ((imm >> 16) << 6) + rb;
    else if (op == 2)  w = w + (rd << 22) + rs;
    else if (op <= 12) w = w + (rd << 17) + (rs << 12);
    else if (op == 13 || op == 16) w = w + (r << 10);
    else if (op == 14) w = w + (((imm >> 16) % 128) << 7);
    else if (op == 15) w = w + (r << 10) + ((imm % 32) << 5) + m;
    return w;
  endfunction

  function automatic bit loses_bits(input logic [31:0] op, imm);
    if (op <= 1)  return (imm % 65536) != 0;
    if (op == 14) return ((imm >> 23) != 0) || ((imm % 65536) != 0);
    if (op == 15) return (imm >> 5) != 0;
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_next = '0; m_last_w = '0; m_last_a = '0; m_trunc = 0; m_ill = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, r, rd, rs, rb, m, input logic [31:0] imm);
    in_valid = v; opcode = op; R = r; Rd = rd; Rs = rs; Rb = rb; M = m; immediate = imm;
  endtask

  // called just after a falling edge with inputs already set
  task automatic cycle();
    ent_t e;
    bit legal;
    #1;
    check("in_ready", in_ready, q.size() < DEPTH);
    m_acc = in_valid && (q.size() < DEPTH);
    legal = (opcode <= 18);
    m_ill = m_acc && !legal;
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (m_acc && legal) begin
      e.a = base_load ? base_addr : m_next;
      e.w = enc(opcode, R, Rd, Rs, Rb, M, immediate);
      q.push_back(e);
      m_next = e.a + 1'b1;
    end else if (base_load) begin
      m_next = base_addr;
    end
    if (m_acc && legal && loses_bits(opcode, immediate)) m_trunc = 1;
    else if (clear_flags) m_trunc = 0;
    @(posedge clock); #1;
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      m_last_w = q[0].w; m_last_a = q[0].a;
    end
    check("out_word", out_word, m_last_w);
    check("out_addr", out_addr, m_last_a);
    check("illegal_opcode", illegal_opcode, m_ill);
    check("imm_truncated", imm_truncated, m_trunc);
    @(negedge clock);
  endtask

  initial begin
    reset = 0; out_ready = 0; base_load = 0; base_addr = '0; clear_flags = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock); @(negedge clock);
    check("rst out_valid", out_valid, 0);
    check("rst out_word", out_word, 0);
    check("rst out_addr", out_addr, 0);
    check("rst in_ready", in_ready, 0);
    check("rst flags", {illegal_opcode, imm_truncated}, 0);
    reset = 1;

    // ADD Rd=3 Rs=5
    drive(1, 3, 0, 3, 5, 0, 0, 0); cycle();
    check("add word", out_word, 32'h18065000);
    check("add addr", out_addr, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); out_ready = 1; cycle();

    // LW then BRFL
    out_ready = 0;
    drive(1, 0, 0, 1, 0, 2, 0, 32'h12340000); cycle();
    drive(1, 15, 4, 0, 0, 0, 7, 32'h3); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("lw word", out_word, 32'h00448D02);
    check("lw addr", out_addr, 1);
    out_ready = 1; cycle();
    check("brfl word", out_word, 32'h78001067);
    check("brfl trunc", imm_truncated, 0);
    cycle();

    // JPC, then truncating JPC, then clear
    drive(1, 14, 0, 0, 0, 0, 0, 32'h005A0000); cycle();
    check("jpc word", out_word, 32'h70002D00);
    drive(1, 14, 0, 0, 0, 0, 0, 32'h005A0001); cycle();
    check("jpc trunc word", out_word, 32'h70002D00);
    check("jpc trunc flag", imm_truncated, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); clear_flags = 1; cycle();
    clear_flags = 0;
    check("cleared", imm_truncated, 0);

    // illegal opcode then NOP
    drive(1, 31, 0, 0, 0, 0, 0, 0); cycle();
    check("illegal pulse", illegal_opcode, 1);
    drive(1, 18, 0, 0, 0, 0, 0, 0); cycle();
    check("illegal one-shot", illegal_opcode, 0);
    check("nop word", out_word, 32'h90000000);
    check("nop addr", out_addr, 5);
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();

    // fill FIFO with base load, then drain with wrap
    out_ready = 0;
    drive(1, 18, 0, 0, 0, 0, 0, 0);
    base_load = 1; base_addr = 8'hFE; cycle(); base_load = 0;
    repeat (3) cycle();
    check("full in_ready", in_ready, 0);
    cycle();
    out_ready = 1;
    for (int i = 0; i < 10 && in_valid; i++) begin
      cycle();
      if (m_acc) in_valid = 0;
    end
    check("fifth accepted", m_acc, 1);
    repeat (6) cycle();

    // reset mid-stream with 3 words buffered
    out_ready = 0;
    drive(1, 2, 0, 1, 2, 0, 0, 0); repeat (3) cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 0; #1;
    model_reset();
    check("async rst valid", out_valid, 0);
    check("async rst ready", in_ready, 0);
    @(negedge clock); reset = 1;
    drive(1, 17, 0, 0, 0, 0, 0, 0); cycle();
    check("post-rst addr", out_addr, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); out_ready = 1; cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      logic [4:0] op;
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      imm = $urandom;
      case ($urandom_range(0, 3))
        0: imm = imm & 32'hFFFF0000;
        1: imm = imm & 32'h007F0000;
        2: imm = imm & 32'h0000001F;
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), imm);
      out_ready   = $urandom_range(0, 2) != 0;
      base_load   = $urandom_range(0, 15) == 0;
      base_addr   = AW'($urandom);
      clear_flags = $urandom_range(0, 7) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
